// File: rtl/echo_delay.sv
// echo_delay: stereo recirculating echo. Each accepted sample pair is truncated
// to MEM_D_WIDTH and mixed with an attenuated copy of the sample i_delay periods
// earlier, read from a per-channel circular buffer. The mix is written back
// into the buffer, which produces decaying repeats.
module echo_delay #(
    parameter int D_WIDTH     = 24,
    parameter int MEM_D_WIDTH = 16,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  i_dv,
    input  logic [D_WIDTH-1:0]    i_l_data,
    input  logic [D_WIDTH-1:0]    i_r_data,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_delay,
    input  logic [1:0]            i_gain,
    output logic [D_WIDTH-1:0]    o_l_data,
    output logic [D_WIDTH-1:0]    o_r_data,
    output logic                  o_dv,
    output logic                  o_busy
);

    localparam int M     = MEM_D_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, READ, WAIT, MIX, WRITE} state_t;

    state_t state, state_next;

    // Latched sample pair and controls for the pair in flight
    logic [D_WIDTH-1:0]    l_in, r_in;
    logic                  en;
    logic [1:0]            gain;
    logic [ADDR_WIDTH-1:0] d;

    logic [ADDR_WIDTH-1:0] wr_ptr, fill, rd_addr;
    logic [M-1:0]          q_l, q_r, e_l, e_r, y_l, y_r;
    logic [M-1:0]          x_l, x_r, wd_l, wd_r;
    logic                  ram_we, hist_ok;

    logic [M-1:0] mem_l [0:DEPTH-1];
    logic [M-1:0] mem_r [0:DEPTH-1];

    assign x_l     = l_in[D_WIDTH-1 -: M];
    assign x_r     = r_in[D_WIDTH-1 -: M];
    assign rd_addr = wr_ptr - d;
    assign hist_ok = (d <= fill);
    assign ram_we  = (state == WRITE) && !reset;
    assign wd_l    = en ? y_l : x_l;
    assign wd_r    = en ? y_r : x_r;
    assign o_busy  = (state != IDLE);

    // Saturating mix: x + (e >>> (g+1)) in M+1 bits, clamped to M-bit signed range
    function automatic logic [M-1:0] mix(input logic [M-1:0] x,
                                         input logic [M-1:0] e,
                                         input logic [1:0]   g);
        logic signed [M:0] xs, es, s;
        logic        [2:0] sh;
        sh = {1'b0, g} + 3'd1;
        xs = signed'({x[M-1], x});
        es = signed'({e[M-1], e}) >>> sh;
        s  = xs + es;
        if (s[M] != s[M-1])
            mix = s[M] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
        else
            mix = s[M-1:0];
    endfunction

    // State register
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Fixed five-step sequence per accepted pair; i_dv outside IDLE is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_dv) state_next = READ;
            READ:    state_next = WAIT;
            WAIT:    state_next = MIX;
            MIX:     state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the sample pair and controls on acceptance; delay 0 acts as 1
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            l_in <= '0;
            r_in <= '0;
            en   <= 1'b0;
            gain <= '0;
            d    <= ADDR_WIDTH'(1);
        end else if (state == IDLE && i_dv) begin
            l_in <= i_l_data;
            r_in <= i_r_data;
            en   <= i_enable;
            gain <= i_gain;
            d    <= (i_delay == '0) ? ADDR_WIDTH'(1) : i_delay;
        end
    end

    // Buffer storage: synchronous read every cycle, write only in WRITE; never reset
    always_ff @(posedge mclk) begin
        q_l <= mem_l[rd_addr];
        q_r <= mem_r[rd_addr];
        if (ram_we) begin
            mem_l[wr_ptr] <= wd_l;
            mem_r[wr_ptr] <= wd_r;
        end
    end

    // Echo registers: history older than what was written since reset reads as 0
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            e_l <= '0;
            e_r <= '0;
            y_l <= '0;
            y_r <= '0;
        end else begin
            if (state == WAIT) begin
                e_l <= hist_ok ? q_l : '0;
                e_r <= hist_ok ? q_r : '0;
            end
            if (state == MIX) begin
                y_l <= mix(x_l, e_l, gain);
                y_r <= mix(x_r, e_r, gain);
            end
        end
    end

    // Write pointer wraps; fill saturates so it can gate stale RAM contents
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (state == WRITE) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (fill != '1) fill <= fill + ADDR_WIDTH'(1);
        end
    end

    // Output registers: update only together with the one-cycle o_dv strobe
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            o_l_data <= '0;
            o_r_data <= '0;
            o_dv     <= 1'b0;
        end else begin
            o_dv <= 1'b0;
            if (state == WRITE) begin
                o_dv     <= 1'b1;
                o_l_data <= en ? {y_l, {(D_WIDTH-M){1'b0}}} : l_in;
                o_r_data <= en ? {y_r, {(D_WIDTH-M){1'b0}}} : r_in;
            end
        end
    end

endmodule
